// File: rtl/dmem_mmio.sv
// Data memory plus a four-register I/O window for a single-cycle 16-bit CPU.
// Loads are combinational from pre-edge state; all stores commit on the rising edge.
module dmem_mmio #(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [15:0] IO_BASE = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mw,
  input  logic [15:0] addr,
  input  logic [15:0] wd,
  output logic [15:0] rd,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic        io_valid,
  output logic        fault
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [15:0] mem_q [Depth];
  logic [15:0] io_out_q, io_out_d;
  logic [15:0] io_in_q;
  logic [15:0] cycle_q, cycle_d;
  logic        io_valid_q, io_valid_d;
  logic        fault_q, fault_d;

  logic        ram_hit, io_hit, unmapped;
  logic [15:0] io_off;
  logic        sel_out, sel_in, sel_cyc, sel_stat;

  // RAM decode wins if the window ever overlaps it; widened so ADDR_W=16 still works.
  assign ram_hit  = ({16'd0, addr} < (32'd1 << ADDR_W));
  assign io_off   = addr - IO_BASE;
  assign io_hit   = !ram_hit && (addr >= IO_BASE) && (io_off < 16'd4);
  assign sel_out  = io_hit && (io_off == 16'd0);
  assign sel_in   = io_hit && (io_off == 16'd1);
  assign sel_cyc  = io_hit && (io_off == 16'd2);
  assign sel_stat = io_hit && (io_off == 16'd3);
  assign unmapped = !ram_hit && !io_hit;

  always_comb begin
    rd = 16'h0000;
    if (ram_hit) begin
      rd = mem_q[addr[ADDR_W-1:0]];
    end else if (sel_out) begin
      rd = io_out_q;
    end else if (sel_in) begin
      rd = io_in_q;
    end else if (sel_cyc) begin
      rd = cycle_q;
    end else if (sel_stat) begin
      rd = {15'b0, fault_q};
    end
  end

  always_comb begin
    io_out_d   = io_out_q;
    io_valid_d = 1'b0;
    if (mw && sel_out) begin
      io_out_d   = wd;
      io_valid_d = 1'b1;
    end
    cycle_d = (mw && sel_cyc) ? 16'h0000 : cycle_q + 16'd1;
    fault_d = fault_q;
    if (mw && sel_stat) begin
      fault_d = 1'b0;
    end else if (mw && unmapped) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_out_q   <= 16'h0000;
      io_valid_q <= 1'b0;
      io_in_q    <= 16'h0000;
      cycle_q    <= 16'h0000;
      fault_q    <= 1'b0;
    end else begin
      io_out_q   <= io_out_d;
      io_valid_q <= io_valid_d;
      io_in_q    <= io_in;
      cycle_q    <= cycle_d;
      fault_q    <= fault_d;
    end
  end

  // RAM has no reset; a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && mw && ram_hit) begin
      mem_q[addr[ADDR_W-1:0]] <= wd;
    end
  end

  assign io_out   = io_out_q;
  assign io_valid = io_valid_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: directed scenarios, a full counter wrap and random traffic
// checked against an address-map reference model.
module tb_dmem_mmio;

  localparam int unsigned ADDR_W  = 8;
  localparam logic [15:0] IO_BASE = 16'hFF00;
  localparam int          RamWords = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        rst, mw;
  logic [15:0] addr, wd, rd, io_in, io_out;
  logic        io_valid, fault;

  dmem_mmio #(.ADDR_W(ADDR_W), .IO_BASE(IO_BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .mw       (mw),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_valid (io_valid),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic        rd_known;
    logic [15:0] rd;
    logic [15:0] io_out;
    logic        io_valid;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;

  // Reference model state
  logic [15:0] m_mem [RamWords];
  bit          m_ok  [RamWords];
  logic [15:0] m_out, m_inq, m_cyc;
  logic        m_valid, m_fault;

  task automatic chk(input string name, input int step, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.rd_known) chk("rd", e.step, rd, e.rd);
      chk("io_out", e.step, io_out, e.io_out);
      chk("io_valid", e.step, {15'b0, io_valid}, {15'b0, e.io_valid});
      chk("fault", e.step, {15'b0, fault}, {15'b0, e.fault});
    end
  end

  function automatic bit is_ram(input logic [15:0] a);
    return int'(a) < RamWords;
  endfunction

  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] inp);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mw = w; addr = a; wd = d; io_in = inp;
    e.step     = n_step++;
    e.rd_known = 1'b1;
    e.io_out   = m_out;
    e.io_valid = m_valid;
    e.fault    = m_fault;
    if (is_ram(a)) begin
      e.rd_known = m_ok[int'(a)];
      e.rd       = m_mem[int'(a)];
    end else if (a == IO_BASE)         e.rd = m_out;
    else if (a == IO_BASE + 16'd1)     e.rd = m_inq;
    else if (a == IO_BASE + 16'd2)     e.rd = m_cyc;
    else if (a == IO_BASE + 16'd3)     e.rd = {15'b0, m_fault};
    else                               e.rd = 16'h0000;
    sb.push_back(e);
    // State after the coming edge
    if (r) begin
      m_out = 0; m_valid = 0; m_fault = 0; m_cyc = 0; m_inq = 0;
    end else begin
      m_inq   = inp;
      m_valid = w && (a == IO_BASE);
      if (m_valid) m_out = d;
      m_cyc = (w && a == IO_BASE + 16'd2) ? 16'h0000 : m_cyc + 16'd1;
      if (w && a == IO_BASE + 16'd3) m_fault = 1'b0;
      else if (w && !is_ram(a) && (a < IO_BASE || a > IO_BASE + 16'd3)) m_fault = 1'b1;
      if (w && is_ram(a)) begin
        m_mem[int'(a)] = d;
        m_ok[int'(a)]  = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic [15:0] a);
    step(1'b0, 1'b0, a, 16'h0000, 16'(($urandom)));
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    case ($urandom_range(0, 5))
      0, 1:    a = 16'($urandom_range(0, 15));
      2:       a = IO_BASE + 16'($urandom_range(0, 3));
      3:       a = 16'($urandom_range(RamWords, 16'hFEFF));
      4:       a = 16'($urandom_range(16'hFF04, 16'hFFFF));
      default: a = 16'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    rst = 1'b1; mw = 1'b0; addr = 16'h0000; wd = 16'h0000; io_in = 16'h0000;
    m_out = 0; m_valid = 0; m_fault = 0; m_cyc = 0; m_inq = 0;
    for (int i = 0; i < RamWords; i++) begin
      m_ok[i]  = 1'b0;
      m_mem[i] = 16'h0000;
    end
    repeat (2) @(posedge clk);

    // Counter counts up from reset
    repeat (5) step(1'b0, 1'b0, IO_BASE + 16'd2, 16'h0000, 16'h0000);
    // RAM write then read-back, low and top word
    step(1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000);
    idle(16'h0005);
    step(1'b0, 1'b1, 16'(RamWords - 1), 16'h1234, 16'h0000);
    idle(16'(RamWords - 1));
    // Output port single and back-to-back writes
    step(1'b0, 1'b1, IO_BASE, 16'h00A5, 16'h0000);
    idle(IO_BASE);
    idle(IO_BASE);
    step(1'b0, 1'b1, IO_BASE, 16'h0001, 16'h0000);
    step(1'b0, 1'b1, IO_BASE, 16'h0002, 16'h0000);
    idle(IO_BASE);
    idle(IO_BASE + 16'd1);
    // Unmapped write sets sticky fault; unmapped reads never do
    idle(16'h0100);
    step(1'b0, 1'b1, 16'h0100, 16'h7777, 16'h0000);
    repeat (10) idle(IO_BASE + 16'd3);
    idle(16'h0100);
    step(1'b0, 1'b1, IO_BASE + 16'd3, 16'hFFFF, 16'h0000);
    idle(16'h0100);
    idle(IO_BASE + 16'd3);
    // Input port writes are ignored
    step(1'b0, 1'b1, IO_BASE + 16'd1, 16'hAAAA, 16'h4321);
    idle(IO_BASE + 16'd1);
    // Clear counter and run it through the wrap
    step(1'b0, 1'b1, IO_BASE + 16'd2, 16'h9999, 16'h0000);
    repeat (65538) step(1'b0, 1'b0, IO_BASE + 16'd2, 16'h0000, 16'h0000);
    // Reset discards a concurrent RAM write
    step(1'b0, 1'b1, 16'h0003, 16'h1111, 16'h0000);
    step(1'b0, 1'b1, IO_BASE, 16'h00FF, 16'h0000);
    step(1'b0, 1'b1, 16'h0200, 16'h0000, 16'h0000);
    step(1'b1, 1'b1, 16'h0003, 16'h5555, 16'h0000);
    idle(16'h0003);
    idle(IO_BASE + 16'd2);
    idle(IO_BASE + 16'd2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), rand_addr(),
           16'($urandom), 16'($urandom));
    end
    @(posedge clk);
    #1;
    mw = 1'b0; rst = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
